// File: rtl/pdl_challenge_sequencer.sv
// Challenge sequencer for a delay-line arbiter PUF: runs VOTES trials per
// challenge pair, majority-votes each response bit and flags non-unanimous bits.
module pdl_challenge_sequencer #(
  parameter int unsigned RESP_BITS     = 16,
  parameter int unsigned VOTES         = 7,
  parameter int unsigned SETTLE_CYCLES = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start_valid,
  output logic                   start_ready,
  input  logic [2*RESP_BITS-1:0] challenge,
  output logic                   puf_reset,
  output logic                   challenge_top,
  output logic                   challenge_bottom,
  output logic                   signal,
  output logic                   trigger,
  input  logic                   response_bit,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [RESP_BITS-1:0]   response,
  output logic [RESP_BITS-1:0]   unstable
);

  localparam int unsigned CW = $clog2(SETTLE_CYCLES);
  localparam int unsigned TW = (VOTES > 1) ? $clog2(VOTES) : 1;
  localparam int unsigned BW = (RESP_BITS > 1) ? $clog2(RESP_BITS) : 1;
  localparam int unsigned OW = $clog2(VOTES + 1);

  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
  localparam logic [TW-1:0] TRIAL_LAST  = TW'(VOTES - 1);
  localparam logic [BW-1:0] BIT_LAST    = BW'(RESP_BITS - 1);
  localparam logic [OW-1:0] HALF_VOTES  = OW'(VOTES / 2);
  localparam logic [OW-1:0] ALL_VOTES   = OW'(VOTES);

  typedef enum logic [2:0] {
    IDLE, CLEAR, SETUP, FIRE, SETTLE, SAMPLE, RELAX, DONE
  } state_t;

  state_t                 state, state_next;
  logic [CW-1:0]          cnt;
  logic [TW-1:0]          trial;
  logic [BW-1:0]          bit_idx;
  logic [OW-1:0]          ones;
  logic [2*RESP_BITS-1:0] challenge_q;
  logic                   sync_meta, sync_out;

  always_comb begin
    state_next  = state;
    start_ready = 1'b0;
    puf_reset   = 1'b0;
    signal      = 1'b0;
    trigger     = 1'b0;
    case (state)
      IDLE: begin
        start_ready = !reset;
        if (start_valid && !reset) state_next = CLEAR;
      end
      CLEAR: begin
        puf_reset = 1'b1;
        if (cnt == CW'(1)) state_next = SETUP;
      end
      SETUP: begin
        signal     = 1'b1;
        state_next = FIRE;
      end
      FIRE: begin
        signal     = 1'b1;
        trigger    = 1'b1;
        state_next = SETTLE;
      end
      SETTLE: begin
        signal  = 1'b1;
        trigger = 1'b1;
        if (cnt == SETTLE_LAST) state_next = SAMPLE;
      end
      SAMPLE: begin
        signal     = 1'b1;
        trigger    = 1'b1;
        state_next = RELAX;
      end
      RELAX: begin
        if (trial != TRIAL_LAST || bit_idx != BIT_LAST) state_next = CLEAR;
        else                                            state_next = DONE;
      end
      DONE: begin
        if (resp_valid && resp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= IDLE;
      cnt              <= '0;
      trial            <= '0;
      bit_idx          <= '0;
      ones             <= '0;
      challenge_q      <= '0;
      challenge_top    <= 1'b0;
      challenge_bottom <= 1'b0;
      sync_meta        <= 1'b0;
      sync_out         <= 1'b0;
      resp_valid       <= 1'b0;
      response         <= '0;
      unstable         <= '0;
    end else begin
      state     <= state_next;
      sync_meta <= response_bit;
      sync_out  <= sync_meta;

      if (state_next != state)                  cnt <= '0;
      else if (state == CLEAR || state == SETTLE) cnt <= cnt + 1'b1;

      case (state)
        IDLE: begin
          if (start_valid && start_ready) begin
            challenge_q <= challenge;
            trial       <= '0;
            bit_idx     <= '0;
            ones        <= '0;
            response    <= '0;
            unstable    <= '0;
          end
        end
        CLEAR: begin
          // Challenge lines are registered here so they hold from SETUP through RELAX.
          if (state_next == SETUP) begin
            challenge_top    <= challenge_q[{bit_idx, 1'b0}];
            challenge_bottom <= challenge_q[{bit_idx, 1'b1}];
          end
        end
        SAMPLE: ones <= ones + OW'(sync_out);
        RELAX: begin
          if (trial != TRIAL_LAST) begin
            trial <= trial + 1'b1;
          end else begin
            response[bit_idx] <= (ones > HALF_VOTES);
            unstable[bit_idx] <= (ones != '0) && (ones != ALL_VOTES);
            ones              <= '0;
            trial             <= '0;
            if (bit_idx != BIT_LAST) bit_idx <= bit_idx + 1'b1;
          end
        end
        default: ;
      endcase

      // Registered one cycle behind DONE entry; drops on the handshake edge.
      resp_valid <= (state == DONE) && !(resp_valid && resp_ready);
    end
  end

endmodule

// File: tb/tb_pdl_challenge_sequencer.sv
// Directed bench for pdl_challenge_sequencer (RESP_BITS=4, VOTES=3, SETTLE_CYCLES=4)
// with a behavioural PUF model driven from the challenge lines or a trial counter.
module tb_pdl_challenge_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start_valid = 1'b0;
  logic       start_ready;
  logic [7:0] challenge = '0;
  logic       puf_reset, challenge_top, challenge_bottom, signal, trigger;
  logic       response_bit;
  logic       resp_valid;
  logic       resp_ready = 1'b0;
  logic [3:0] response, unstable;

  pdl_challenge_sequencer #(
    .RESP_BITS(4),
    .VOTES(3),
    .SETTLE_CYCLES(4)
  ) dut (
    .clk(clk), .reset(reset),
    .start_valid(start_valid), .start_ready(start_ready),
    .challenge(challenge),
    .puf_reset(puf_reset), .challenge_top(challenge_top),
    .challenge_bottom(challenge_bottom), .signal(signal), .trigger(trigger),
    .response_bit(response_bit),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .response(response), .unstable(unstable)
  );

  always #5 clk = ~clk;

  // PUF model: mode 0 = top XOR bottom, 1 = ones on global trials 6 and 8, 2 = constant 1
  int unsigned mode = 0;
  int unsigned trial_cnt = 0;
  logic        trig_d = 1'b0;

  always @(negedge clk) begin
    trig_d <= trigger;
    if (start_valid && start_ready)  trial_cnt <= 0;
    else if (trig_d && !trigger)     trial_cnt <= trial_cnt + 1;
  end

  always_comb begin
    response_bit = 1'b0;
    case (mode)
      0: response_bit = challenge_top ^ challenge_bottom;
      1: response_bit = (trial_cnt == 6) || (trial_cnt == 8);
      2: response_bit = 1'b1;
      default: response_bit = 1'b0;
    endcase
  end

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  int   pr_run, tg_run, pulses;
  logic chg_err, busy_ready_err, prev_trig, prev_top, prev_bot;

  task automatic trace_init();
    pr_run = 0; tg_run = 0; pulses = 0;
    chg_err = 1'b0; busy_ready_err = 1'b0;
    prev_trig = 1'b0; prev_top = 1'b0; prev_bot = 1'b0;
  endtask

  task automatic observe();
    if (puf_reset) pr_run++;
    else if (pr_run != 0) begin check("puf_reset_len", pr_run, 2); pr_run = 0; end
    if (trigger) tg_run++;
    else if (tg_run != 0) begin check("trigger_len", tg_run, 6); tg_run = 0; pulses++; end
    if (trigger && prev_trig && (challenge_top !== prev_top || challenge_bottom !== prev_bot))
      chg_err = 1'b1;
    if (start_ready) busy_ready_err = 1'b1;
    prev_trig = trigger; prev_top = challenge_top; prev_bot = challenge_bottom;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_start_ready"}, start_ready, 0);
    check({tag, "_resp_valid"}, resp_valid, 0);
    check({tag, "_puf_reset"}, puf_reset, 0);
    check({tag, "_trigger"}, trigger, 0);
    check({tag, "_signal"}, signal, 0);
    check({tag, "_ch_top"}, challenge_top, 0);
    check({tag, "_ch_bottom"}, challenge_bottom, 0);
    check({tag, "_response"}, response, 0);
    check({tag, "_unstable"}, unstable, 0);
  endtask

  typedef struct {
    logic [7:0]  ch;
    int unsigned mode;
    logic [3:0]  resp;
    logic [3:0]  unst;
    int unsigned hold;
  } vec_t;

  // Called at #1 after a rising edge with the DUT idle.
  task automatic run_txn(input vec_t v);
    int n;
    logic hold_err;
    challenge   = v.ch;
    mode        = v.mode;
    start_valid = 1'b1;
    check("start_ready_idle", start_ready, 1);
    @(posedge clk); #1;
    start_valid = 1'b0;
    challenge   = v.ch ^ 8'h55;  // flips every XOR result if the DUT used the live bus
    trace_init();
    n = 0;
    observe();
    while (!resp_valid && n < 200) begin
      @(posedge clk); #1;
      n++;
      start_valid = (n >= 5 && n <= 8);
      observe();
    end
    start_valid = 1'b0;
    check("resp_latency", n, 121);
    check("trigger_pulses", pulses, 12);
    check("challenge_stable_in_trigger", chg_err, 0);
    check("start_ready_busy", busy_ready_err, 0);
    check("response", response, v.resp);
    check("unstable", unstable, v.unst);
    hold_err = 1'b0;
    for (int i = 0; i < int'(v.hold); i++) begin
      @(posedge clk); #1;
      if (!resp_valid || response !== v.resp || unstable !== v.unst || start_ready)
        hold_err = 1'b1;
    end
    if (v.hold != 0) check("hold_stable", hold_err, 0);
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    check("valid_drop_on_ready", resp_valid, 0);
    check("idle_after_ready", start_ready, 1);
    @(posedge clk); #1;
    check("no_queued_start", puf_reset, 0);
  endtask

  vec_t vecs[6];

  initial begin
    int   n;
    logic ghost;
    vec_t v;

    vecs[0] = '{8'b01_10_11_00, 0, 4'b1100, 4'b0000, 0};
    vecs[1] = '{8'hFF,          0, 4'b0000, 4'b0000, 0};
    vecs[2] = '{8'b10_01_10_01, 0, 4'b1111, 4'b0000, 20};
    vecs[3] = '{8'b00_00_01_10, 0, 4'b0011, 4'b0000, 0};
    vecs[4] = '{8'hA5,          1, 4'b0100, 4'b0100, 0};
    vecs[5] = '{8'h3C,          2, 4'b1111, 4'b0000, 0};

    repeat (3) @(posedge clk);
    #1;
    start_valid = 1'b1;
    check_reset_outputs("in_reset");
    start_valid = 1'b0;
    reset = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++) run_txn(vecs[i]);

    // Abort during the first SETTLE of bit 1 (pair 1 = 11 so the lines are high)
    challenge   = 8'b11_10_11_01;
    mode        = 0;
    start_valid = 1'b1;
    @(posedge clk); #1;
    start_valid = 1'b0;
    n = 0;
    while (n < 35) begin @(posedge clk); #1; n++; end
    check("trigger_in_settle", trigger, 1);
    check("top_before_reset", challenge_top, 1);
    reset = 1'b1;
    @(posedge clk); #1;
    check_reset_outputs("abort");
    reset = 1'b0;
    ghost = 1'b0;
    for (int i = 0; i < 130; i++) begin
      @(posedge clk); #1;
      if (resp_valid || puf_reset) ghost = 1'b1;
    end
    check("no_result_after_abort", ghost, 0);
    v = '{8'b11_10_11_01, 0, 4'b0101, 4'b0000, 0};
    run_txn(v);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
